// File: rtl/ccd_line_pkg.sv
// -----------------------------------------------------------------------------
// ccd_line_pkg
//
// Shared types for the CCD line-buffer ping-pong controller.
//   - wr_state_t : capture-side sequencing (WAIT_FRAME, ACTIVE)
//   - rd_state_t : readout-side sequencing (IDLE, READ)
//   - BANK_A / BANK_B : encoding of the two line-buffer RAMs
//   - bank_mask() : one-hot flag mask for a bank index
// -----------------------------------------------------------------------------
package ccd_line_pkg;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } wr_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // One-hot position of a bank inside the two-bit bank_full vector.
  function automatic logic [1:0] bank_mask(input logic bank);
    return (bank == BANK_B) ? 2'b10 : 2'b01;
  endfunction

endpackage : ccd_line_pkg

// File: rtl/ccd_line_reader.sv
// -----------------------------------------------------------------------------
// ccd_line_reader
//
// Read-side sequencer for the ping-pong line buffers. Waits in IDLE until the
// bank it owns is flagged full, then presents that bank to the consumer and
// walks the read address one step per accepted rd_en. The read that consumes
// the last column raises o_bank_clr for one cycle so the top level can free
// the bank, and the reader moves on to the other bank.
//
// Ports
//   clk              in   pixel clock
//   aclr             in   asynchronous active-low reset
//   i_bank_full[1:0] in   full flags for bank A (bit 0) and bank B (bit 1)
//   i_rd_en          in   consumer pulls one pixel
//   o_line_avail     out  a full line is being presented (READ state)
//   o_rd_sel         out  bank being read (0=A, 1=B)
//   o_rd_add         out  read address into the selected bank
//   o_rd_data_valid  out  RAM read data valid (one cycle after accepted rd_en)
//   o_bank_clr       out  strobe: the bank on o_rd_sel is now empty
// -----------------------------------------------------------------------------
module ccd_line_reader
  import ccd_line_pkg::*;
#(
  parameter int COLUMN_SIZE = 1280,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [1:0]        i_bank_full,
  input  logic              i_rd_en,
  output logic              o_line_avail,
  output logic              o_rd_sel,
  output logic [ADDR_W-1:0] o_rd_add,
  output logic              o_rd_data_valid,
  output logic              o_bank_clr
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLUMN_SIZE - 1);

  rd_state_t         r_rd_state;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_rd_add;
  logic              r_rd_data_valid;

  logic w_rd_accept;
  logic w_rd_last;

  // rd_en only counts while a line is presented; in IDLE it is ignored.
  assign w_rd_accept = (r_rd_state == READ) && i_rd_en;
  assign w_rd_last   = w_rd_accept && (r_rd_add == LAST_COL);

  // NOTE: every state register here uses <= so all of them sample the same
  // pre-edge values; blocking assignments would let later lines see updates.
  // NOTE: only control registers are reset; the RAM contents are not, since
  // the full flags already say whether a bank holds meaningful data.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_rd_state      <= IDLE;
      r_rd_bank       <= BANK_A;
      r_rd_add        <= '0;
      r_rd_data_valid <= 1'b0;
    end else begin
      // The RAM has one cycle of read latency.
      r_rd_data_valid <= w_rd_accept;
      case (r_rd_state)
        IDLE: begin
          if (i_bank_full[r_rd_bank]) begin
            r_rd_state <= READ;
            r_rd_add   <= '0;
          end
        end
        READ: begin
          if (w_rd_last) begin
            r_rd_add   <= '0;
            r_rd_bank  <= ~r_rd_bank;
            r_rd_state <= IDLE;
          end else if (w_rd_accept) begin
            r_rd_add <= r_rd_add + ADDR_W'(1);
          end
        end
        default: r_rd_state <= IDLE;
      endcase
    end
  end

  assign o_line_avail    = (r_rd_state == READ);
  assign o_rd_sel        = r_rd_bank;
  assign o_rd_add        = r_rd_add;
  assign o_rd_data_valid = r_rd_data_valid;
  assign o_bank_clr      = w_rd_last;

endmodule : ccd_line_reader

// File: rtl/ccd_line_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// ccd_line_pingpong_ctrl
//
// Ping-pong sequencer for the two CCD line-buffer RAMs. The write side accepts
// capture pixels into the bank selected by wr_bank, counting columns in step
// with the external write-address generator (which increments on each wren),
// and flags a bank full once a whole line has landed. The read side
// (ccd_line_reader) drains full banks for the demosaic stage and frees them.
// A pixel whose target bank is still full is dropped and sets a sticky
// overflow flag. Frames are armed by frame_start and end after ROW_SIZE lines.
//
// Ports
//   clk              in   pixel clock
//   aclr             in   asynchronous active-low reset (shared with the
//                         write-address generator)
//   i_frame_start    in   pulse: arm capture of a new frame
//   i_pix_valid      in   capture pixel present this cycle
//   o_rama_wren      out  bank A write enable / address increment
//   o_ramb_wren      out  bank B write enable / address increment
//   o_wr_row         out  lines completed in the current frame
//   o_frame_done     out  one-cycle pulse after the last line of a frame
//   o_overflow       out  sticky: a pixel was dropped on a full bank
//   i_rd_en          in   consumer pulls one pixel
//   o_line_avail     out  a full line is being presented for reading
//   o_rd_sel         out  bank being read (0=A, 1=B)
//   o_rd_add         out  read address into the selected bank
//   o_rd_data_valid  out  read data valid, one cycle after an accepted rd_en
//
// Parameters must satisfy 2**ADDR_W >= COLUMN_SIZE and 2**ROW_W >= ROW_SIZE.
// -----------------------------------------------------------------------------
module ccd_line_pingpong_ctrl
  import ccd_line_pkg::*;
#(
  parameter int COLUMN_SIZE = 1280,
  parameter int ROW_SIZE    = 1024,
  parameter int ADDR_W      = 11,
  parameter int ROW_W       = 10
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              i_frame_start,
  input  logic              i_pix_valid,
  output logic              o_rama_wren,
  output logic              o_ramb_wren,
  output logic [ROW_W-1:0]  o_wr_row,
  output logic              o_frame_done,
  output logic              o_overflow,
  input  logic              i_rd_en,
  output logic              o_line_avail,
  output logic              o_rd_sel,
  output logic [ADDR_W-1:0] o_rd_add,
  output logic              o_rd_data_valid
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLUMN_SIZE - 1);
  // One extra bit so the end-of-frame compare works even when ROW_SIZE is
  // exactly 2**ROW_W (wr_row then rolls to 0 on the final line).
  localparam logic [ROW_W:0]    ROW_END  = (ROW_W + 1)'(ROW_SIZE);

  wr_state_t         r_wr_state;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_col;
  logic [ROW_W-1:0]  r_wr_row;
  logic              r_frame_done;
  logic              r_overflow;
  logic [1:0]        r_bank_full;

  logic              w_active;
  logic              w_target_full;
  logic              w_accept;
  logic              w_drop;
  logic              w_line_end;
  logic [ROW_W:0]    w_row_inc;
  logic              w_frame_end;
  logic [1:0]        w_set_mask;
  logic [1:0]        w_clr_mask;
  logic              w_rd_clr;
  logic              w_rd_sel;

  assign w_active      = (r_wr_state == ACTIVE);
  assign w_target_full = r_bank_full[r_wr_bank];
  assign w_accept      = w_active && i_pix_valid && !w_target_full;
  assign w_drop        = w_active && i_pix_valid &&  w_target_full;
  assign w_line_end    = w_accept && (r_wr_col == LAST_COL);
  assign w_row_inc     = {1'b0, r_wr_row} + (ROW_W + 1)'(1);
  assign w_frame_end   = w_line_end && (w_row_inc == ROW_END);

  // Write enables are combinational so the address generator advances in the
  // same cycle as the pixel it stores.
  assign o_rama_wren = w_accept && (r_wr_bank == BANK_A);
  assign o_ramb_wren = w_accept && (r_wr_bank == BANK_B);

  // A set needs the bank empty and a clear needs the read bank full, so the
  // two masks never hit the same bit in one cycle.
  assign w_set_mask = w_line_end ? bank_mask(r_wr_bank) : 2'b00;
  assign w_clr_mask = w_rd_clr   ? bank_mask(w_rd_sel)  : 2'b00;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_wr_state   <= WAIT_FRAME;
      r_wr_bank    <= BANK_A;
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_bank_full  <= 2'b00;
    end else begin
      r_frame_done <= 1'b0;
      r_bank_full  <= (r_bank_full | w_set_mask) & ~w_clr_mask;

      if (w_accept) begin
        if (w_line_end) begin
          r_wr_col  <= '0;
          r_wr_bank <= ~r_wr_bank;
          r_wr_row  <= w_row_inc[ROW_W-1:0];
          if (w_frame_end) begin
            r_frame_done <= 1'b1;
            r_wr_state   <= WAIT_FRAME;
          end
        end else begin
          r_wr_col <= r_wr_col + ADDR_W'(1);
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // frame_start wins over the updates above for row count, overflow and
      // state. Column, bank and full flags are left alone so a partial line
      // stays aligned with the external write-address generator.
      if (i_frame_start) begin
        r_wr_row   <= '0;
        r_overflow <= 1'b0;
        r_wr_state <= ACTIVE;
      end
    end
  end

  ccd_line_reader #(
    .COLUMN_SIZE (COLUMN_SIZE),
    .ADDR_W      (ADDR_W)
  ) u_reader (
    .clk             (clk),
    .aclr            (aclr),
    .i_bank_full     (r_bank_full),
    .i_rd_en         (i_rd_en),
    .o_line_avail    (o_line_avail),
    .o_rd_sel        (w_rd_sel),
    .o_rd_add        (o_rd_add),
    .o_rd_data_valid (o_rd_data_valid),
    .o_bank_clr      (w_rd_clr)
  );

  assign o_rd_sel     = w_rd_sel;
  assign o_wr_row     = r_wr_row;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;

endmodule : ccd_line_pingpong_ctrl

// File: tb/tb_ccd_line_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ccd_line_pingpong_ctrl
//
// Directed bench for the ping-pong controller with COLUMN_SIZE=4, ROW_SIZE=3.
// Stimulus tasks push the expected writes (bank, column) and reads (bank,
// address) into queues; a monitor pops and compares whenever the DUT raises a
// write enable or accepts a read, and tracks rd_data_valid one cycle behind.
// -----------------------------------------------------------------------------
module tb_ccd_line_pingpong_ctrl;

  localparam int COL  = 4;
  localparam int ROWS = 3;
  localparam int AW   = 11;
  localparam int RW   = 10;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          rama_wren, ramb_wren, frame_done, overflow;
  logic          line_avail, rd_sel, rd_data_valid;
  logic [RW-1:0] wr_row;
  logic [AW-1:0] rd_add;

  always #5 clk = ~clk;

  ccd_line_pingpong_ctrl #(
    .COLUMN_SIZE (COL),
    .ROW_SIZE    (ROWS),
    .ADDR_W      (AW),
    .ROW_W       (RW)
  ) dut (
    .clk             (clk),
    .aclr            (aclr),
    .i_frame_start   (frame_start),
    .i_pix_valid     (pix_valid),
    .o_rama_wren     (rama_wren),
    .o_ramb_wren     (ramb_wren),
    .o_wr_row        (wr_row),
    .o_frame_done    (frame_done),
    .o_overflow      (overflow),
    .i_rd_en         (rd_en),
    .o_line_avail    (line_avail),
    .o_rd_sel        (rd_sel),
    .o_rd_add        (rd_add),
    .o_rd_data_valid (rd_data_valid)
  );

  typedef struct packed { logic bank; logic [AW-1:0] col; } wr_exp_t;
  typedef struct packed { logic sel;  logic [AW-1:0] add; } rd_exp_t;

  wr_exp_t wq[$];
  rd_exp_t rq[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    logic    prev_acc;
    logic    acc;
    wr_exp_t we;
    rd_exp_t re;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!aclr) begin
        prev_acc = 1'b0;
      end else begin
        if (rama_wren || ramb_wren) begin
          check("wren_exclusive", 32'(rama_wren & ramb_wren), 0);
          if (wq.size() == 0) begin
            check("unexpected_wren", 32'({ramb_wren, rama_wren}), 0);
          end else begin
            we = wq.pop_front();
            check("wr_bank", 32'(ramb_wren), 32'(we.bank));
            check("wr_col", 32'(dut.r_wr_col), 32'(we.col));
          end
        end
        if (prev_acc || rd_data_valid)
          check("rd_data_valid", 32'(rd_data_valid), 32'(prev_acc));
        acc = line_avail && rd_en;
        if (acc) begin
          if (rq.size() == 0) begin
            check("unexpected_read", 32'(rd_add), 32'hFFFF_FFFF);
          end else begin
            re = rq.pop_front();
            check("rd_sel", 32'(rd_sel), 32'(re.sel));
            check("rd_add", 32'(rd_add), 32'(re.add));
          end
        end
        prev_acc = acc;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_flags"}, 32'({rama_wren, ramb_wren, frame_done, overflow,
                                line_avail, rd_sel, rd_data_valid}), 0);
    check({tag, "_wr_row"}, 32'(wr_row), 0);
    check({tag, "_rd_add"}, 32'(rd_add), 0);
    check({tag, "_bank_full"}, 32'(dut.r_bank_full), 0);
    check({tag, "_wr_col"}, 32'(dut.r_wr_col), 0);
  endtask

  task automatic do_reset();
    rd_en       = 1'b0;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    tick();
    aclr = 1'b0;
    #1;
    check_zero_outs("rst");
    wq.delete();
    rq.delete();
    tick();
    aclr = 1'b1;
    tick();
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pixels(input int n);
    pix_valid = 1'b1;
    repeat (n) tick();
    pix_valid = 1'b0;
  endtask

  task automatic push_wr(input logic bank, input int col);
    wq.push_back('{bank: bank, col: AW'(col)});
  endtask

  task automatic push_wr_line(input logic bank);
    for (int c = 0; c < COL; c++) push_wr(bank, c);
  endtask

  task automatic push_rd_line(input logic sel);
    for (int a = 0; a < COL; a++) rq.push_back('{sel: sel, add: AW'(a)});
  endtask

  task automatic wait_rd_drain(input int max_cycles);
    int k;
    k = 0;
    while (rq.size() != 0 && k < max_cycles) begin
      tick();
      k++;
    end
    check("rd_drain_left", rq.size(), 0);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin : stim
    // Reset and one line
    repeat (2) @(posedge clk);
    #1;
    check_zero_outs("por");
    aclr = 1'b1;
    tick();
    pulse_frame_start();
    check("s1_wr_row_arm", 32'(wr_row), 0);
    push_wr_line(1'b0);
    pixels(4);
    check("s1_bank_full", 32'(dut.r_bank_full), 32'h1);
    check("s1_wr_row", 32'(wr_row), 1);
    check("s1_avail_early", 32'(line_avail), 0);
    tick();
    check("s1_avail", 32'(line_avail), 1);
    check("s1_rd_sel", 32'(rd_sel), 0);
    check("s1_rd_add0", 32'(rd_add), 0);
    check("s1_wq_left", wq.size(), 0);
    push_rd_line(1'b0);
    rd_en = 1'b1;
    wait_rd_drain(10);
    rd_en = 1'b0;
    repeat (2) tick();
    check("s1_bank_free", 32'(dut.r_bank_full), 0);

    // Ping-pong with the reader always pulling
    do_reset();
    pulse_frame_start();
    push_wr_line(1'b0);
    push_wr_line(1'b1);
    push_rd_line(1'b0);
    push_rd_line(1'b1);
    rd_en = 1'b1;
    pixels(8);
    wait_rd_drain(20);
    rd_en = 1'b0;
    repeat (2) tick();
    check("s2_overflow", 32'(overflow), 0);
    check("s2_wr_row", 32'(wr_row), 2);
    check("s2_bank_full", 32'(dut.r_bank_full), 0);
    check("s2_frame_done", 32'(frame_done), 0);
    check("s2_wq_left", wq.size(), 0);

    // Overflow: nobody reads, pixels 9..12 are dropped
    do_reset();
    pulse_frame_start();
    push_wr_line(1'b0);
    push_wr_line(1'b1);
    pixels(12);
    check("s3_overflow", 32'(overflow), 1);
    check("s3_wr_row", 32'(wr_row), 2);
    check("s3_bank_full", 32'(dut.r_bank_full), 32'h3);
    check("s3_wq_left", wq.size(), 0);
    pulse_frame_start();
    check("s3_ovf_cleared", 32'(overflow), 0);
    check("s3_row_cleared", 32'(wr_row), 0);
    check("s3_flags_kept", 32'(dut.r_bank_full), 32'h3);

    // Frame end with the reader draining between lines
    do_reset();
    pulse_frame_start();
    push_wr_line(1'b0);
    push_wr_line(1'b1);
    push_wr_line(1'b0);
    push_rd_line(1'b0);
    push_rd_line(1'b1);
    push_rd_line(1'b0);
    rd_en = 1'b1;
    pixels(4);
    repeat (4) tick();
    pixels(4);
    repeat (4) tick();
    pixels(3);
    check("s4_done_early", 32'(frame_done), 0);
    pixels(1);
    check("s4_frame_done", 32'(frame_done), 1);
    check("s4_wr_row", 32'(wr_row), 3);
    pixels(1);
    check("s4_done_pulse", 32'(frame_done), 0);
    check("s4_no_overflow", 32'(overflow), 0);
    wait_rd_drain(30);
    rd_en = 1'b0;
    tick();
    pulse_frame_start();
    check("s4_rearm_row", 32'(wr_row), 0);
    push_wr(1'b1, 0);
    pixels(1);
    check("s4_wq_left", wq.size(), 0);

    // Mid-line reset
    do_reset();
    pulse_frame_start();
    push_wr(1'b0, 0);
    push_wr(1'b0, 1);
    pix_valid = 1'b1;
    repeat (2) tick();
    aclr = 1'b0;
    #1;
    check_zero_outs("s5_rst");
    tick();
    aclr      = 1'b1;
    pix_valid = 1'b0;
    tick();
    check("s5_wq_left", wq.size(), 0);
    pulse_frame_start();
    push_wr_line(1'b0);
    pixels(4);
    check("s5_bank_full", 32'(dut.r_bank_full), 32'h1);
    tick();
    check("s5_avail", 32'(line_avail), 1);
    check("s5_rd_sel", 32'(rd_sel), 0);

    // Read gaps: rd_en toggling 1/0
    push_rd_line(1'b0);
    for (int i = 0; i < COL; i++) begin
      rd_en = 1'b1;
      tick();
      check("s6_rd_add_step", 32'(rd_add), (i == COL - 1) ? 0 : i + 1);
      if (i == COL - 1) begin
        check("s6_avail_drop", 32'(line_avail), 0);
        check("s6_rdv_tail", 32'(rd_data_valid), 1);
      end
      rd_en = 1'b0;
      tick();
      check("s6_rd_add_hold", 32'(rd_add), (i == COL - 1) ? 0 : i + 1);
      check("s6_rdv_gap", 32'(rd_data_valid), 0);
    end
    rd_en = 1'b1;
    repeat (3) tick();
    check("s6_idle_avail", 32'(line_avail), 0);
    check("s6_idle_add", 32'(rd_add), 0);
    check("s6_idle_rdv", 32'(rd_data_valid), 0);
    rd_en = 1'b0;
    tick();
    check("s6_rq_left", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_ccd_line_pingpong_ctrl
